// File: rtl/token_sched_pkg.sv
// Shared constants and types for the round-robin token scheduler.
// Per-stream config fields are sized for the widest supported divider.
package token_sched_pkg;

   localparam int unsigned N_DEF     = 4;
   localparam int unsigned CNT_W_DEF = 4;
   localparam int unsigned DIV_W_DEF = 3;
   localparam int unsigned DIV_W_MAX = 8;

   typedef logic [$clog2(N_DEF)-1:0] id_t;

   typedef struct packed {
      logic [DIV_W_MAX-1:0] div;
      logic [DIV_W_MAX-1:0] phase;
   } stream_cfg_t;

   localparam stream_cfg_t STREAM_CFG_RST = '{div: DIV_W_MAX'(1), phase: '0};

endpackage

// File: rtl/token_rr_arbiter.sv
// Combinational round-robin arbiter.
// It grants the first asserted request at or above ptr, wrapping modulo N.
module token_rr_arbiter #(
   parameter int unsigned N = 4
) (
   input  logic [N-1:0]         req,
   input  logic [$clog2(N)-1:0] ptr,
   output logic                 grant_valid,
   output logic [$clog2(N)-1:0] grant_id
);

   localparam int unsigned ID_W = $clog2(N);

   always_comb begin
      logic [ID_W:0]   sum;
      logic [ID_W-1:0] idx;
      grant_valid = 1'b0;
      grant_id    = '0;
      sum         = '0;
      idx         = '0;
      for (int unsigned k = 0; k < N; k++) begin
         // ptr < N and k < N, so one conditional subtract is enough to wrap
         sum = {1'b0, ptr} + (ID_W+1)'(k);
         if (sum >= (ID_W+1)'(N)) sum = sum - (ID_W+1)'(N);
         idx = sum[ID_W-1:0];
         if (!grant_valid && req[idx]) begin
            grant_valid = 1'b1;
            grant_id    = idx;
         end
      end
   end

endmodule

// File: rtl/token_rr_scheduler.sv
// Per-stream decimators feed saturating pending counters.
// A round-robin arbiter drains them into a registered valid/ready output.
module token_rr_scheduler
   import token_sched_pkg::*;
#(
   parameter int unsigned N     = N_DEF,
   parameter int unsigned CNT_W = CNT_W_DEF,
   parameter int unsigned DIV_W = DIV_W_DEF
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [N-1:0]         a,
   input  logic                 cfg_valid,
   input  logic [$clog2(N)-1:0] cfg_id,
   input  logic [DIV_W-1:0]     cfg_div,
   output logic                 cfg_ready,
   output logic                 out_valid,
   output logic [$clog2(N)-1:0] out_id,
   input  logic                 out_ready,
   output logic [N-1:0]         overflow
);

   localparam int unsigned ID_W = $clog2(N);

   logic [N-1:0]    req;
   logic            grant_valid;
   logic [ID_W-1:0] grant_id;
   logic            load;
   logic            grant_fire;

   logic            out_valid_q, out_valid_d;
   logic [ID_W-1:0] out_id_q, out_id_d;
   logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;

   assign cfg_ready  = 1'b1;
   assign load       = !out_valid_q || out_ready;
   assign grant_fire = load && grant_valid;

   for (genvar i = 0; i < N; i++) begin : g_stream
      stream_cfg_t      cfg_q, cfg_d;
      logic [CNT_W-1:0] pend_q, pend_d;
      logic             ovf_q, ovf_d;
      logic             keep;
      logic             grant;

      // A token arriving alongside a config write is judged against the old div
      always_comb begin
         keep  = a[i] && (cfg_q.phase == cfg_q.div);
         cfg_d = cfg_q;
         if (a[i]) cfg_d.phase = keep ? '0 : cfg_q.phase + 1'b1;
         if (cfg_valid && (cfg_id == ID_W'(i))) begin
            cfg_d.div   = DIV_W_MAX'(cfg_div);
            cfg_d.phase = '0;
         end
      end

      always_comb begin
         grant  = grant_fire && (grant_id == ID_W'(i));
         pend_d = pend_q;
         ovf_d  = ovf_q;
         if (keep && !grant) begin
            if (pend_q == {CNT_W{1'b1}}) ovf_d = 1'b1;
            else pend_d = pend_q + 1'b1;
         end else if (!keep && grant) begin
            pend_d = pend_q - 1'b1;
         end
      end

      always_ff @(posedge clk) begin
         if (rst) begin
            cfg_q  <= STREAM_CFG_RST;
            pend_q <= '0;
            ovf_q  <= 1'b0;
         end else begin
            cfg_q  <= cfg_d;
            pend_q <= pend_d;
            ovf_q  <= ovf_d;
         end
      end

      assign req[i]      = (pend_q != '0);
      assign overflow[i] = ovf_q;
   end

   token_rr_arbiter #(
      .N(N)
   ) u_arbiter (
      .req        (req),
      .ptr        (rr_ptr_q),
      .grant_valid(grant_valid),
      .grant_id   (grant_id)
   );

   always_comb begin
      out_valid_d = out_valid_q;
      out_id_d    = out_id_q;
      rr_ptr_d    = rr_ptr_q;
      if (load) begin
         out_valid_d = grant_valid;
         if (grant_valid) begin
            out_id_d = grant_id;
            rr_ptr_d = (grant_id == ID_W'(N-1)) ? '0 : grant_id + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         out_id_q    <= '0;
         rr_ptr_q    <= '0;
      end else begin
         out_valid_q <= out_valid_d;
         out_id_q    <= out_id_d;
         rr_ptr_q    <= rr_ptr_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_id    = out_id_q;

endmodule

// File: tb/tb_token_rr_scheduler.sv
// Bench for token_rr_scheduler: directed scenarios plus randomized traffic
// compared against an integer-level model of the scheduling rules.
module tb_token_rr_scheduler;
   import token_sched_pkg::*;

   localparam int NS  = 4;
   localparam int MAX = 15;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] a = '0;
   logic       cfg_valid = 1'b0;
   id_t        cfg_id = '0;
   logic [2:0] cfg_div = '0;
   logic       cfg_ready;
   logic       out_valid;
   id_t        out_id;
   logic       out_ready = 1'b1;
   logic [3:0] overflow;

   int n_tests = 0;
   int n_fail  = 0;

   int m_div[NS];
   int m_phase[NS];
   int m_pend[NS];
   bit m_ovf[NS];
   int m_ptr;
   bit m_valid;
   int m_id;

   always #5 clk = ~clk;

   token_rr_scheduler #(
      .N(4),
      .CNT_W(4),
      .DIV_W(3)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .a        (a),
      .cfg_valid(cfg_valid),
      .cfg_id   (cfg_id),
      .cfg_div  (cfg_div),
      .cfg_ready(cfg_ready),
      .out_valid(out_valid),
      .out_id   (out_id),
      .out_ready(out_ready),
      .overflow (overflow)
   );

   // Reference: grant chosen from counts before this edge, then counts updated
   task automatic model_step();
      int  g;
      int  p;
      bit  slot;
      bit  kept;
      if (rst) begin
         for (int i = 0; i < NS; i++) begin
            m_div[i] = 1; m_phase[i] = 0; m_pend[i] = 0; m_ovf[i] = 0;
         end
         m_ptr = 0; m_valid = 0; m_id = 0;
         return;
      end
      slot = !m_valid || out_ready;
      g = -1;
      if (slot)
         for (int k = 0; k < NS; k++)
            if (g < 0 && m_pend[(m_ptr + k) % NS] > 0) g = (m_ptr + k) % NS;
      for (int i = 0; i < NS; i++) begin
         kept = a[i] && (m_phase[i] == m_div[i]);
         if (a[i]) m_phase[i] = kept ? 0 : m_phase[i] + 1;
         if (cfg_valid && int'(cfg_id) == i) begin
            m_div[i] = int'(cfg_div);
            m_phase[i] = 0;
         end
         p = m_pend[i] + int'(kept) - int'(g == i);
         if (p > MAX) begin
            p = MAX;
            m_ovf[i] = 1;
         end
         m_pend[i] = p;
      end
      if (slot) begin
         if (g >= 0) begin
            m_valid = 1; m_id = g; m_ptr = (g + 1) % NS;
         end else begin
            m_valid = 0;
         end
      end
   endtask

   function automatic logic [3:0] model_ovf();
      logic [3:0] v;
      for (int i = 0; i < NS; i++) v[i] = m_ovf[i];
      return v;
   endfunction

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; a = '0; cfg_valid = 1'b0; out_ready = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic cfg_write(input int id, input int dv);
      cfg_valid = 1'b1; cfg_id = id_t'(id); cfg_div = 3'(dv);
      tick();
      cfg_valid = 1'b0;
   endtask

   task automatic test_reset();
      a = 4'hF; cfg_valid = 1'b1; out_ready = 1'b0;
      rst = 1'b1;
      tick();
      tick();
      n_tests++;
      if (out_valid !== 1'b0) begin
         n_fail++; $display("FAIL reset_out_valid: got %0b want 0", out_valid);
      end
      n_tests++;
      if (out_id !== 2'd0) begin
         n_fail++; $display("FAIL reset_out_id: got %0d want 0", out_id);
      end
      n_tests++;
      if (overflow !== 4'b0) begin
         n_fail++; $display("FAIL reset_overflow: got %b want 0000", overflow);
      end
      n_tests++;
      if (cfg_ready !== 1'b1) begin
         n_fail++; $display("FAIL reset_cfg_ready: got %0b want 1", cfg_ready);
      end
      cfg_valid = 1'b0;
      rst = 1'b0;
   endtask

   task automatic test_default_halving();
      logic [15:0] patv;
      int          ones;
      int          got;
      int          exp_q[$];
      patv = 16'b1100_1110_1000_1111;
      ones = 0;
      got  = 0;
      do_reset();
      for (int c = 0; c < 20; c++) begin
         a = (c < 16) ? {3'b000, patv[15-c]} : 4'b0000;
         if (a[0]) begin
            ones++;
            if (ones % 2 == 0) exp_q.push_back(c + 1);
         end
         tick();
         n_tests++;
         if (out_valid !== m_valid || (m_valid && int'(out_id) != m_id)) begin
            n_fail++;
            $display("FAIL halving_model c=%0d: got v=%0b id=%0d want v=%0b id=%0d",
                     c, out_valid, out_id, m_valid, m_id);
         end
         if (out_valid === 1'b1) begin
            got++;
            n_tests++;
            if (exp_q.size() == 0 || exp_q[0] != c || out_id !== 2'd0) begin
               n_fail++;
               $display("FAIL halving_timing c=%0d: got id=%0d want id=0 at cycle %0d",
                        c, out_id, (exp_q.size() > 0) ? exp_q[0] : -1);
            end
            if (exp_q.size() > 0 && exp_q[0] == c) void'(exp_q.pop_front());
         end
      end
      a = '0;
      n_tests++;
      if (got != 5) begin
         n_fail++; $display("FAIL halving_count: got %0d want 5", got);
      end
   endtask

   task automatic test_round_robin();
      do_reset();
      for (int i = 0; i < NS; i++) cfg_write(i, 0);
      a = 4'hF;
      tick();
      a = '0;
      for (int k = 1; k <= 5; k++) begin
         tick();
         n_tests++;
         if (k <= 4) begin
            if (out_valid !== 1'b1 || int'(out_id) != k - 1) begin
               n_fail++;
               $display("FAIL rr_order k=%0d: got v=%0b id=%0d want v=1 id=%0d",
                        k, out_valid, out_id, k - 1);
            end
         end else if (out_valid !== 1'b0) begin
            n_fail++; $display("FAIL rr_drained: got v=%0b want 0", out_valid);
         end
      end
   endtask

   task automatic test_backpressure();
      int delivered;
      do_reset();
      cfg_write(2, 0);
      out_ready = 1'b0;
      for (int c = 0; c < 10; c++) begin
         a = (c < 3) ? 4'b0100 : 4'b0000;
         tick();
         if (c >= 1) begin
            n_tests++;
            if (out_valid !== 1'b1 || out_id !== 2'd2) begin
               n_fail++;
               $display("FAIL bp_stable c=%0d: got v=%0b id=%0d want v=1 id=2",
                        c, out_valid, out_id);
            end
         end
      end
      a = '0;
      out_ready = 1'b1;
      delivered = 0;
      for (int c = 0; c < 8; c++) begin
         if (out_valid === 1'b1 && out_ready) delivered++;
         tick();
      end
      n_tests++;
      if (delivered != 3) begin
         n_fail++; $display("FAIL bp_delivered: got %0d want 3", delivered);
      end
   endtask

   task automatic test_overflow();
      int delivered;
      do_reset();
      cfg_write(1, 0);
      out_ready = 1'b0;
      a = 4'b0010;
      for (int c = 0; c < 20; c++) tick();
      a = '0;
      tick();
      n_tests++;
      if (overflow !== 4'b0010) begin
         n_fail++; $display("FAIL ovf_flag: got %b want 0010", overflow);
      end
      out_ready = 1'b1;
      delivered = 0;
      for (int c = 0; c < 24; c++) begin
         if (out_valid === 1'b1) begin
            delivered++;
            n_tests++;
            if (out_id !== 2'd1) begin
               n_fail++; $display("FAIL ovf_id: got %0d want 1", out_id);
            end
         end
         tick();
      end
      n_tests++;
      if (delivered != 16) begin
         n_fail++; $display("FAIL ovf_retained: got %0d want 16", delivered);
      end
      n_tests++;
      if (overflow !== 4'b0010) begin
         n_fail++; $display("FAIL ovf_sticky: got %b want 0010", overflow);
      end
   endtask

   task automatic test_config_midstream();
      int  delivered;
      bit  want;
      do_reset();
      out_ready = 1'b1;
      a = 4'b1000;
      tick();
      cfg_valid = 1'b1; cfg_id = 2'd3; cfg_div = 3'd2;
      tick();
      cfg_valid = 1'b0;
      a = '0;
      tick();
      n_tests++;
      if (out_valid !== 1'b1 || out_id !== 2'd3) begin
         n_fail++;
         $display("FAIL cfg_old_div: got v=%0b id=%0d want v=1 id=3", out_valid, out_id);
      end
      delivered = 0;
      for (int c = 0; c < 14; c++) begin
         a = (c < 9) ? 4'b1000 : 4'b0000;
         if (out_valid === 1'b1) delivered++;
         tick();
         want = (c == 3 || c == 6 || c == 9);
         n_tests++;
         if (out_valid !== want) begin
            n_fail++;
            $display("FAIL cfg_every_third c=%0d: got v=%0b want v=%0b", c, out_valid, want);
         end
      end
      a = '0;
      n_tests++;
      if (delivered != 4) begin
         n_fail++; $display("FAIL cfg_delivered: got %0d want 4", delivered);
      end
   endtask

   task automatic test_random();
      do_reset();
      for (int c = 0; c < 600; c++) begin
         a         = 4'($urandom);
         cfg_valid = ($urandom_range(0, 15) == 0);
         cfg_id    = id_t'($urandom);
         cfg_div   = 3'($urandom);
         out_ready = ((c % 150) < 70) ? ($urandom_range(0, 7) == 0)
                                      : ($urandom_range(0, 3) != 0);
         rst       = ($urandom_range(0, 249) == 0);
         tick();
         n_tests++;
         if (out_valid !== m_valid || (m_valid && int'(out_id) != m_id)) begin
            n_fail++;
            $display("FAIL random_out c=%0d: got v=%0b id=%0d want v=%0b id=%0d",
                     c, out_valid, out_id, m_valid, m_id);
         end
         n_tests++;
         if (overflow !== model_ovf()) begin
            n_fail++;
            $display("FAIL random_ovf c=%0d: got %b want %b", c, overflow, model_ovf());
         end
      end
      rst = 1'b0; a = '0; cfg_valid = 1'b0; out_ready = 1'b1;
   endtask

   initial begin
      test_reset();
      test_default_halving();
      test_round_robin();
      test_backpressure();
      test_overflow();
      test_config_midstream();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
